// File: rtl/jt12_slot_seq.sv
// Slot sequencer: walks the 24-slot frame (6 channels x 4 operators) and emits per-slot accumulator control.
// Latency: slot outputs are registered and update on the edge that consumes clk_en.
// Config writes go to a shadow bank that commits to the active bank atomically at frame end.
module jt12_slot_seq #(
  parameter int SLOTS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [1:0] cfg_rl,
  input  logic [2:0] cfg_alg,
  input  logic       cfg_mute,
  output logic       cfg_err,
  output logic       cfg_pending,
  output logic       zero,
  output logic       s1_enters,
  output logic       s2_enters,
  output logic       s3_enters,
  output logic       s4_enters,
  output logic       ch6op,
  output logic [2:0] cur_ch,
  output logic [1:0] rl,
  output logic [2:0] alg,
  output logic       channel_en,
  output logic [7:0] frame_cnt
);

  typedef struct packed {
    logic [1:0] rl;
    logic [2:0] alg;
    logic       mute;
  } cfg_t;

  localparam cfg_t       CFG_RST  = '{rl: 2'b11, alg: 3'd0, mute: 1'b0};
  localparam logic [1:0] LAST_GRP = 2'(SLOTS / 6 - 1);

  // Next slot kept as (channel, operator group) so decode needs no division.
  logic [2:0] nxt_ch_q;
  logic [1:0] nxt_grp_q;

  cfg_t shadow_q [6];
  cfg_t shadow_d [6];
  cfg_t active_q [6];
  cfg_t cur_cfg;

  logic wr_ok;
  logic commit;

  logic       cfg_err_q, cfg_pending_q, zero_q, ch6op_q, channel_en_q;
  logic       s1_q, s2_q, s3_q, s4_q;
  logic [2:0] cur_ch_q, alg_q;
  logic [1:0] rl_q;
  logic [7:0] frame_cnt_q;

  assign wr_ok  = cfg_we && (cfg_ch < 3'd6);
  assign commit = clk_en && (nxt_ch_q == 3'd5) && (nxt_grp_q == LAST_GRP);

  // Shadow bank with this cycle's write applied; the commit copies this so a same-cycle write is included.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_ok && (cfg_ch == 3'(i))) begin
        shadow_d[i] = '{rl: cfg_rl, alg: cfg_alg, mute: cfg_mute};
      end
    end
  end

  // Active-bank entry for the slot about to be presented (bank as it stands before any commit this edge).
  always_comb begin
    cur_cfg = CFG_RST;
    for (int i = 0; i < 6; i++) begin
      if (nxt_ch_q == 3'(i)) begin
        cur_cfg = active_q[i];
      end
    end
  end

  // Sequencer, banks and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_ch_q      <= 3'd0;
      nxt_grp_q     <= 2'd0;
      cfg_err_q     <= 1'b0;
      cfg_pending_q <= 1'b0;
      zero_q        <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      s4_q          <= 1'b0;
      ch6op_q       <= 1'b0;
      cur_ch_q      <= 3'd0;
      rl_q          <= 2'd0;
      alg_q         <= 3'd0;
      channel_en_q  <= 1'b0;
      frame_cnt_q   <= 8'd0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= CFG_RST;
        active_q[i] <= CFG_RST;
      end
    end else begin
      cfg_err_q <= cfg_we && (cfg_ch >= 3'd6);
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (commit) begin
          active_q[i] <= shadow_d[i];
        end
      end
      if (commit) begin
        cfg_pending_q <= 1'b0;
      end else if (wr_ok) begin
        cfg_pending_q <= 1'b1;
      end
      if (clk_en) begin
        zero_q       <= (nxt_ch_q == 3'd0) && (nxt_grp_q == 2'd0);
        // Operator groups in frame order: S1, S3, S2, S4.
        s1_q         <= (nxt_grp_q == 2'd0);
        s3_q         <= (nxt_grp_q == 2'd1);
        s2_q         <= (nxt_grp_q == 2'd2);
        s4_q         <= (nxt_grp_q == 2'd3);
        ch6op_q      <= (nxt_ch_q == 3'd5);
        cur_ch_q     <= nxt_ch_q;
        rl_q         <= cur_cfg.rl;
        alg_q        <= cur_cfg.alg;
        channel_en_q <= ~cur_cfg.mute;
        if ((nxt_ch_q == 3'd0) && (nxt_grp_q == 2'd0)) begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
        if (nxt_ch_q == 3'd5) begin
          nxt_ch_q  <= 3'd0;
          nxt_grp_q <= (nxt_grp_q == LAST_GRP) ? 2'd0 : nxt_grp_q + 2'd1;
        end else begin
          nxt_ch_q <= nxt_ch_q + 3'd1;
        end
      end
    end
  end

  assign cfg_err     = cfg_err_q;
  assign cfg_pending = cfg_pending_q;
  assign zero        = zero_q;
  assign s1_enters   = s1_q;
  assign s2_enters   = s2_q;
  assign s3_enters   = s3_q;
  assign s4_enters   = s4_q;
  assign ch6op       = ch6op_q;
  assign cur_ch      = cur_ch_q;
  assign rl          = rl_q;
  assign alg         = alg_q;
  assign channel_en  = channel_en_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
